pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch sequencer that owns the program counter register and its write enable. Each cycle it decides whether the PC holds, increments, or loads a redirect target. It drives a request/acknowledge fetch to instruction memory and presents fetched instructions to decode with a valid/ready handshake. It sits between the PC register, instruction memory and decode; stall handling, branch/jump redirect and halt are all resolved here.

## Interface
- ADDR_W, 15, PC / instruction address width
- INSTR_W, 16, instruction word width
- RESET_VEC, 15'h0000, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= pcaddout)
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction (ignored when instr_valid=0)
- instr_out  out  INSTR_W  registered instruction
- instr_pc  out  ADDR_W  address instr_out was fetched from
- redirect  in  1  load redirect_pc (branch taken / jump)
- redirect_pc  in  ADDR_W  redirect target
- halt_req  in  1  stop fetching after the current instruction
- pcaddout  out  ADDR_W  current PC (registered)
- PCWrite  out  1  one-cycle pulse, high in the cycle after pcaddout changed
- halted  out  1  sequencer stopped

## Operation
- States: IDLE, FETCH, VALID, HALTED.
- Reset values: state=IDLE, pcaddout=RESET_VEC, instr_out=0, instr_pc=0, instr_valid=0, PCWrite=0, halted=0, squash=0. imem_req is 0 because it is decoded from state.
- imem_req = (state==FETCH); imem_addr = pcaddout; both stay stable until imem_ack.
- IDLE: go to FETCH next cycle. If halt_req is high, go to HALTED instead.
- FETCH on imem_ack:
  - squash=0: capture instr_out=imem_rdata and instr_pc=pcaddout; go to VALID.
  - squash=1: discard the data, clear squash, stay in FETCH (new request at the redirected PC).
- VALID: instr_valid=1. On instr_ready:
  - pcaddout = pcaddout+1, modulo 2^ADDR_W (7FFF wraps to 0000).
  - Go to FETCH, or to HALTED if halt_req is high.
  - Without instr_ready: instr_out, instr_pc and pcaddout hold.
- Redirect, in any state except HALTED:
  - pcaddout = redirect_pc.
  - In VALID, the held instruction is dropped: instr_valid=0 next cycle, go to FETCH.
  - In FETCH with imem_ack absent, set squash=1. The request continues at the new address only after the outstanding ack; imem_addr changes immediately, and memory must latch the address on its request.
  - In FETCH with imem_ack present, discard the data and stay in FETCH.
- Redirect and accept in the same cycle: the instruction counts as consumed, and redirect_pc wins over +1.
- Redirect and halt_req together: pcaddout = redirect_pc, then go to HALTED.
- HALTED: imem_req=0, instr_valid=0, halted=1, PC frozen; redirect is ignored. Only rst exits HALTED.
- Reset asserted mid-fetch returns all outputs to reset values immediately. Any ack arriving during or after reset, before the first new request, is ignored.

## Timing
- IDLE lasts 1 cycle after reset release; the first imem_req is in cycle 2.
- Ack in cycle N: instr_valid=1 from cycle N+1.
- Accept in cycle M: next imem_req in cycle M+1.
- Zero-wait memory with ready tied high: 1 instruction per 2 cycles.
- PCWrite is high exactly one cycle per pcaddout change (increment or redirect), never otherwise.
- The PC update is visible on pcaddout the cycle after the accept or redirect edge.

## Test plan
- Reset, zero-wait memory, instr_ready=1 -> imem_addr 0000,0001,0002,... in alternating cycles; instr_pc matches; PCWrite pulses after each accept.
- imem_ack delayed 3 cycles at 0004 -> imem_req/imem_addr stable for 4 cycles; exactly one instr_valid with instr_pc=0004.
- instr_ready low 4 cycles while VALID at 0009 -> instr_out, instr_pc and pcaddout held; no PCWrite; advances to 000A one cycle after ready.
- Redirect to 0100 while fetch of 0005 is outstanding, ack 2 cycles later -> 0005 data never valid; next request addr 0100; one PCWrite pulse.
- PC 7FFF accepted -> pcaddout=0000, next imem_addr=0000.
- halt_req with accept at 0003 -> halted=1, no further imem_req, pcaddout=0004. Then rst pulse mid-stream -> pcaddout=0000, instr_valid=0 asynchronously, fetching resumes from 0000.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC and its write strobe, fetches over req/ack
// and hands instructions to decode over a valid/ready handshake.
module pc_sequencer #(
  parameter int unsigned           ADDR_W    = 15,
  parameter int unsigned           INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_VEC = 15'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  pcaddout,
  output logic               PCWrite,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_VALID  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_next_pc;
  logic [ADDR_W-1:0]    w_pc_inc;
  logic                 r_squash;
  logic                 w_next_squash;
  logic                 w_capture;
  logic [INSTR_W-1:0]   r_instr;
  logic [ADDR_W-1:0]    r_instr_pc;
  logic                 r_valid;
  logic                 r_pcwrite;
  logic                 r_halted;

  assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_next_state  = r_state;
    w_next_pc     = r_pc;
    w_next_squash = r_squash;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_next_pc = redirect_pc;
        end else begin
          w_next_pc = r_pc;
        end
        if (halt_req) begin
          w_next_state = S_HALTED;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          w_next_pc = redirect_pc;
          // An ack this cycle retires the old request; otherwise its ack is still owed.
          if (halt_req) begin
            w_next_state  = S_HALTED;
            w_next_squash = 1'b0;
          end else begin
            w_next_squash = ~imem_ack;
          end
        end else if (imem_ack) begin
          if (r_squash) begin
            w_next_squash = 1'b0;
          end else begin
            w_capture    = 1'b1;
            w_next_state = S_VALID;
          end
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_VALID: begin
        if (redirect || instr_ready) begin
          if (redirect) begin
            w_next_pc = redirect_pc;
          end else begin
            w_next_pc = w_pc_inc;
          end
          if (halt_req) begin
            w_next_state = S_HALTED;
          end else begin
            w_next_state = S_FETCH;
          end
        end else begin
          w_next_state = S_VALID;
        end
      end
      S_HALTED: begin
        w_next_state  = S_HALTED;
        w_next_squash = 1'b0;
      end
      default: begin
        w_next_state  = S_IDLE;
        w_next_squash = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VEC;
      r_squash   <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_pcwrite  <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_next_pc;
      r_squash   <= w_next_squash;
      r_pcwrite  <= (w_next_pc != r_pc);
      r_valid    <= (w_next_state == S_VALID);
      r_halted   <= (w_next_state == S_HALTED);
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end else begin
        r_instr    <= r_instr;
        r_instr_pc <= r_instr_pc;
      end
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign pcaddout    = r_pc;
  assign instr_valid = r_valid;
  assign instr_out   = r_instr;
  assign instr_pc    = r_instr_pc;
  assign PCWrite     = r_pcwrite;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: a variable-latency memory and random
// decode/redirect/halt/reset traffic, checked against a flag-based model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [14:0] instr_pc;
  logic        redirect;
  logic [14:0] redirect_pc;
  logic        halt_req;
  logic [14:0] pcaddout;
  logic        PCWrite;
  logic        halted;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt_req   (halt_req),
    .pcaddout   (pcaddout),
    .PCWrite    (PCWrite),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: what the sequencer has, not how it is encoded.
  int m_pc;
  int m_instr;
  int m_ipc;
  bit m_started;
  bit m_valid;
  bit m_halted;
  bit m_drop;
  bit m_pcw;

  // Memory model: one outstanding request, address latched at request.
  bit          mem_busy;
  int          mem_cnt;
  logic [14:0] mem_addr;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    return {a, 1'b1} ^ 16'hA53C;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_ipc = 0;
    m_started = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_drop = 1'b0; m_pcw = 1'b0;
  endtask

  task automatic model_step();
    int npc;
    npc = m_pc;
    if (!m_halted) begin
      if (!m_started) begin
        m_started = 1'b1;
        if (redirect) npc = int'(redirect_pc);
        if (halt_req) m_halted = 1'b1;
      end else if (m_valid) begin
        if (redirect || instr_ready) begin
          npc = redirect ? int'(redirect_pc) : (m_pc + 1) % 32768;
          m_valid = 1'b0;
          if (halt_req) m_halted = 1'b1;
        end
      end else begin
        if (redirect) begin
          npc = int'(redirect_pc);
          m_drop = !imem_ack && !halt_req;
          if (halt_req) m_halted = 1'b1;
        end else if (imem_ack) begin
          if (m_drop) begin
            m_drop = 1'b0;
          end else begin
            m_valid = 1'b1;
            m_instr = int'(imem_rdata);
            m_ipc   = m_pc;
          end
        end
      end
    end
    m_pcw = (npc != m_pc);
    m_pc  = npc;
  endtask

  task automatic compare_all(input string where);
    check_value({where, ".imem_req"},    32'(imem_req),    32'(m_started && !m_valid && !m_halted));
    check_value({where, ".imem_addr"},   32'(imem_addr),   32'(m_pc));
    check_value({where, ".pcaddout"},    32'(pcaddout),    32'(m_pc));
    check_value({where, ".instr_valid"}, 32'(instr_valid), 32'(m_valid));
    check_value({where, ".instr_out"},   32'(instr_out),   32'(m_instr));
    check_value({where, ".instr_pc"},    32'(instr_pc),    32'(m_ipc));
    check_value({where, ".PCWrite"},     32'(PCWrite),     32'(m_pcw));
    check_value({where, ".halted"},      32'(halted),      32'(m_halted));
  endtask

  task automatic pick_controls();
    int r;
    instr_ready = ($urandom_range(0, 9) < 6);
    halt_req    = ($urandom_range(0, 99) == 0);
    redirect    = ($urandom_range(0, 11) == 0);
    r = $urandom_range(0, 3);
    case (r)
      0:       redirect_pc = 15'h7FFF;
      1:       redirect_pc = 15'h0100;
      2:       redirect_pc = 15'h7FFE;
      default: redirect_pc = 15'($urandom);
    endcase
  endtask

  task automatic drive_memory();
    if (!mem_busy && imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
    end
    if (mem_busy && mem_cnt == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(mem_addr);
      mem_busy   = 1'b0;
    end else begin
      if (mem_busy) mem_cnt--;
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 15'h0000; halt_req = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 15'h0000;
    #1 rst = 1'b1;
    model_reset();
    #1 compare_all("por");

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      compare_all("run");
      if (rst) begin
        // Release; stray acks in the idle cycle must be ignored.
        rst = 1'b0;
        pick_controls();
        imem_ack   = 1'b1;
        imem_rdata = 16'($urandom);
        model_step();
      end else if ($urandom_range(0, 199) == 0) begin
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'($urandom);
        redirect   = 1'b0;
        mem_busy   = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
      end else begin
        pick_controls();
        drive_memory();
        model_step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
